byte_word_mem: RTL and testbench

Parametrised byte-addressed data/instruction memory returning big-endian 16-bit words from any byte address, aligned or unaligned. It is the successor of the fixed 40-byte memory and sits between the datapath's address/store-data buses and the instruction/data load path. It adds:
- a protected ROM program region;
- per-byte write enables;
- a registered read with a valid strobe;
- out-of-range and ROM-write error reporting;
- a post-reset RAM clear sequence with a ready handshake.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_rom.sv | 17 +
 rtl/byte_word_mem.sv | 134 +++++++++++++
 tb/tb_byte_word_mem.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressed word memory: boot ROM image,
// default ROM size and the clear/idle controller states.
package mem_pkg;

  localparam int ROM_BYTES_DEFAULT = 6;
  localparam int ROM_IMG_LEN       = 6;

  // Byte 0 is the most significant byte of the constant.
  localparam logic [8*ROM_IMG_LEN-1:0] ROM_IMAGE = 48'hDE_01_8E_05_0D_C1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Bytes past the end of the image read as zero.
  function automatic logic [7:0] rom_byte(input int unsigned idx);
    logic [8*ROM_IMG_LEN-1:0] sh;
    sh = '0;
    if (idx < ROM_IMG_LEN) begin
      sh = ROM_IMAGE >> (8 * (ROM_IMG_LEN - 1 - idx));
    end
    return sh[7:0];
  endfunction

endpackage

// File: rtl/mem_rom.sv
// Combinational two-port lookup into the package ROM image, one port for the
// high byte (Addr) and one for the low byte (Addr+1).
module mem_rom
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W:0] i_idx_hi,
  input  logic [ADDR_W:0] i_idx_lo,
  output logic [7:0]      o_byte_hi,
  output logic [7:0]      o_byte_lo
);

  assign o_byte_hi = rom_byte(32'(i_idx_hi));
  assign o_byte_lo = rom_byte(32'(i_idx_lo));

endmodule

// File: rtl/byte_word_mem.sv
// Byte-addressed memory returning big-endian 16-bit words from any byte
// address, with a read-only boot region, byte enables and a post-reset clear.
module byte_word_mem
  import mem_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = 16,
  parameter int ROM_BYTES      = ROM_BYTES_DEFAULT,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [15:0]       InData,
  input  logic [1:0]        ByteEn,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic              Ready,
  output logic [15:0]       MemOut,
  output logic              MemValid,
  output logic              MemErr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  ROM_X     = (ADDR_W+1)'(ROM_BYTES);
  localparam logic [IDX_W-1:0] CNT_FIRST = IDX_W'(ROM_BYTES);
  localparam logic [IDX_W-1:0] CNT_LAST  = IDX_W'(DEPTH - 1);

  if ((DEPTH % 2) != 0 || DEPTH <= ROM_BYTES + 1) begin : g_bad_params
    $error("byte_word_mem: DEPTH must be even and exceed ROM_BYTES+1");
  end

  state_e           r_state;
  logic [IDX_W-1:0] r_clr_cnt;
  // Only the writable region has storage; ROM bytes come from the image.
  logic [7:0]       r_ram [ROM_BYTES:DEPTH-1];
  logic [15:0]      r_rdata_p1;
  logic             r_vld_p1;
  logic             r_err_p1;

  logic [ADDR_W:0]  w_addr_hi;
  logic [ADDR_W:0]  w_addr_lo;
  logic [IDX_W-1:0] w_idx_hi;
  logic [IDX_W-1:0] w_idx_lo;
  logic             w_acc;
  logic             w_in_range;
  logic             w_hi_rom;
  logic             w_lo_rom;
  logic             w_we_hi;
  logic             w_we_lo;
  logic             w_wr_err;
  logic             w_err;
  logic [7:0]       w_rom_hi;
  logic [7:0]       w_rom_lo;
  logic [7:0]       w_rd_hi;
  logic [7:0]       w_rd_lo;

  // Addr+1 is formed one bit wider so the top address cannot wrap to zero.
  assign w_addr_hi  = {1'b0, Addr};
  assign w_addr_lo  = w_addr_hi + 1'b1;
  assign w_idx_hi   = w_addr_hi[IDX_W-1:0];
  assign w_idx_lo   = w_addr_lo[IDX_W-1:0];
  assign w_in_range = (w_addr_lo < DEPTH_X);
  assign w_hi_rom   = (w_addr_hi < ROM_X);
  assign w_lo_rom   = (w_addr_lo < ROM_X);

  assign Ready = (r_state == IDLE) && !Reset;
  assign w_acc = Ready && (MemRead || MemWrite);

  assign w_we_hi  = w_acc && MemWrite && w_in_range && ByteEn[1] && !w_hi_rom;
  assign w_we_lo  = w_acc && MemWrite && w_in_range && ByteEn[0] && !w_lo_rom;
  assign w_wr_err = MemWrite && (!w_in_range || (ByteEn[1] && w_hi_rom) ||
                                 (ByteEn[0] && w_lo_rom));
  assign w_err    = (MemRead && !w_in_range) || w_wr_err;

  mem_rom #(
    .ADDR_W (ADDR_W)
  ) u_rom (
    .i_idx_hi  (w_addr_hi),
    .i_idx_lo  (w_addr_lo),
    .o_byte_hi (w_rom_hi),
    .o_byte_lo (w_rom_lo)
  );

  assign w_rd_hi = w_hi_rom ? w_rom_hi : r_ram[w_idx_hi];
  assign w_rd_lo = w_lo_rom ? w_rom_lo : r_ram[w_idx_lo];

  // Stage p0 -> p1: controller, read data and strobes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= CLEAR_ON_RESET ? CLEAR : IDLE;
      r_clr_cnt  <= CNT_FIRST;
      r_rdata_p1 <= 16'h0000;
      r_vld_p1   <= 1'b0;
      r_err_p1   <= 1'b0;
    end else begin
      if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
        if (r_clr_cnt == CNT_LAST) begin
          r_state <= IDLE;
        end
      end
      r_vld_p1 <= w_acc && MemRead;
      r_err_p1 <= w_acc && w_err;
      if (w_acc && MemRead) begin
        r_rdata_p1 <= w_in_range ? {w_rd_hi, w_rd_lo} : 16'h0000;
      end
    end
  end

  // RAM storage: the read above samples old contents, giving read-before-write.
  always_ff @(posedge Clk) begin
    if (Reset && !CLEAR_ON_RESET) begin
      for (int i = ROM_BYTES; i < DEPTH; i++) begin
        r_ram[i] <= 8'h00;
      end
    end else if (r_state == CLEAR) begin
      r_ram[r_clr_cnt] <= 8'h00;
    end else begin
      if (w_we_hi) begin
        r_ram[w_idx_hi] <= InData[15:8];
      end
      if (w_we_lo) begin
        r_ram[w_idx_lo] <= InData[7:0];
      end
    end
  end

  assign MemOut   = r_rdata_p1;
  assign MemValid = r_vld_p1;
  assign MemErr   = r_err_p1;

endmodule

// File: tb/tb_byte_word_mem.sv
// Bench for byte_word_mem: directed scenarios plus random traffic, all checked
// against a byte-array model of the memory.
module tb_byte_word_mem;

  localparam int DEPTH     = 64;
  localparam int ROM_BYTES = 6;
  localparam int CLR_CYC   = DEPTH - ROM_BYTES;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] Addr = 16'h0000;
  logic [15:0] InData = 16'h0000;
  logic [1:0]  ByteEn = 2'b00;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic        Ready;
  logic [15:0] MemOut;
  logic        MemValid;
  logic        MemErr;

  int tests = 0;
  int fails = 0;

  byte_word_mem #(
    .DEPTH          (DEPTH),
    .ADDR_W         (16),
    .ROM_BYTES      (ROM_BYTES),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Addr     (Addr),
    .InData   (InData),
    .ByteEn   (ByteEn),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .Ready    (Ready),
    .MemOut   (MemOut),
    .MemValid (MemValid),
    .MemErr   (MemErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as a plain byte array, clear as a cycle countdown.
  logic [7:0]  rom_img [ROM_BYTES] = '{8'hDE, 8'h01, 8'h8E, 8'h05, 8'h0D, 8'hC1};
  logic [7:0]  m_mem [DEPTH];
  int          clr_left = 0;
  bit          started = 1'b0;
  logic [15:0] e_out = 16'h0000;
  logic        e_vld = 1'b0;
  logic        e_err = 1'b0;
  int          m_a;
  int          m_b;
  bit          m_inr;

  always @(posedge Clk) begin
    if (Reset) begin
      started  = 1'b1;
      clr_left = CLR_CYC;
      e_out    = 16'h0000;
      e_vld    = 1'b0;
      e_err    = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = (i < ROM_BYTES) ? rom_img[i] : 8'h00;
    end else if (clr_left > 0) begin
      clr_left = clr_left - 1;
      e_vld    = 1'b0;
      e_err    = 1'b0;
    end else begin
      m_a   = int'(Addr);
      m_inr = (m_a + 1 < DEPTH);
      e_vld = MemRead;
      e_err = (MemRead || MemWrite) && !m_inr;
      if (MemRead) e_out = m_inr ? {m_mem[m_a], m_mem[m_a+1]} : 16'h0000;
      if (MemWrite && m_inr) begin
        for (int k = 0; k < 2; k++) begin
          m_b = m_a + k;
          if (ByteEn[1-k]) begin
            if (m_b < ROM_BYTES) e_err = 1'b1;
            else m_mem[m_b] = (k == 0) ? InData[15:8] : InData[7:0];
          end
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (started) begin
      check("cyc_ready", Ready, (clr_left == 0) && !Reset);
      check("cyc_valid", MemValid, e_vld);
      check("cyc_err", MemErr, e_err);
      check("cyc_out", MemOut, e_out);
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    MemRead  = rd;
    MemWrite = wr;
    Addr     = a;
    InData   = d;
    ByteEn   = be;
    @(posedge Clk); #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!Ready && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    check(name, n, CLR_CYC);
  endtask

  initial begin
    int r;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("reset_out", MemOut, 16'h0000);
    check("reset_ready", Ready, 1'b0);
    wait_ready("clear_latency");

    issue(1, 0, 16'd6, 16'h0, 2'b00);
    check("rd6_out", MemOut, 16'h0000);
    check("rd6_vld", MemValid, 1'b1);
    check("rd6_err", MemErr, 1'b0);
    issue(1, 0, 16'd0, 16'h0, 2'b00);
    check("rd0_out", MemOut, 16'hDE01);
    issue(1, 0, 16'd1, 16'h0, 2'b00);
    check("rd1_out", MemOut, 16'h018E);
    issue(1, 0, 16'd4, 16'h0, 2'b00);
    check("rd4_out", MemOut, 16'h0DC1);

    issue(0, 1, 16'd8, 16'hFF00, 2'b11);
    check("wr8_vld", MemValid, 1'b0);
    issue(1, 0, 16'd8, 16'h0, 2'b00);
    check("rd8_full", MemOut, 16'hFF00);
    issue(0, 1, 16'd8, 16'hAAAA, 2'b01);
    issue(1, 0, 16'd8, 16'h0, 2'b00);
    check("rd8_lowbyte", MemOut, 16'hFFAA);

    issue(0, 1, 16'd2, 16'h1234, 2'b11);
    check("wr_rom_err", MemErr, 1'b1);
    issue(1, 0, 16'd2, 16'h0, 2'b00);
    check("rd2_rom", MemOut, 16'h8E05);
    check("rd2_err", MemErr, 1'b0);
    issue(0, 1, 16'd5, 16'h1234, 2'b11);
    check("wr_straddle_err", MemErr, 1'b1);
    issue(1, 0, 16'd5, 16'h0, 2'b00);
    check("rd5_straddle", MemOut, 16'hC134);

    issue(1, 0, 16'd63, 16'h0, 2'b00);
    check("rd63_out", MemOut, 16'h0000);
    check("rd63_vld", MemValid, 1'b1);
    check("rd63_err", MemErr, 1'b1);
    issue(0, 1, 16'd63, 16'hBEEF, 2'b11);
    check("wr63_err", MemErr, 1'b1);
    issue(1, 0, 16'd62, 16'h0, 2'b00);
    check("rd62_out", MemOut, 16'h0000);

    issue(1, 1, 16'd10, 16'hBEEF, 2'b11);
    check("rbw_out", MemOut, 16'h0000);
    check("rbw_vld", MemValid, 1'b1);
    issue(1, 0, 16'd10, 16'h0, 2'b00);
    check("rd10_out", MemOut, 16'hBEEF);

    // Dirty byte 40, then reset again partway through the clear.
    issue(0, 1, 16'd40, 16'h5A5A, 2'b11);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    MemRead = 1'b1;
    Addr = 16'd12;
    repeat (20) begin
      @(posedge Clk); #1;
    end
    check("midclr_ready", Ready, 1'b0);
    check("midclr_novld", MemValid, 1'b0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    wait_ready("reclear_latency");
    MemRead = 1'b0;
    issue(1, 0, 16'd40, 16'h0, 2'b00);
    check("rd40_cleared", MemOut, 16'h0000);
    check("rd40_vld", MemValid, 1'b1);

    // Random back-to-back traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      r        = int'($urandom_range(0, 99));
      Reset    = (i == 1500);
      MemRead  = 1'($urandom_range(0, 1));
      MemWrite = 1'($urandom_range(0, 1));
      if (r < 85)      Addr = 16'($urandom_range(0, 63));
      else if (r < 95) Addr = 16'($urandom_range(60, 80));
      else if (r < 99) Addr = 16'($urandom);
      else             Addr = 16'hFFFF;
      InData = 16'($urandom);
      ByteEn = 2'($urandom_range(0, 3));
      @(posedge Clk); #1;
    end
    Reset    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
